// File: rtl/game_pkg.sv
// Shared game types: FSM state encoding, BCD digit type and a binary-to-BCD
// helper used to build compile-time score constants.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_WIN      = 2'd3
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Values above 99 clamp to 99 so the result always fits two digits.
    function automatic logic [7:0] bin_to_bcd(input int unsigned value);
        int unsigned v;
        v = (value > 99) ? 99 : value;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_incrementer.sv
// Two-digit BCD +1 with enable; saturates at 99 instead of wrapping.
module bcd_incrementer
    import game_pkg::*;
(
    input  logic       en_i,
    input  bcd_digit_t tens_i,
    input  bcd_digit_t ones_i,
    output bcd_digit_t tens_o,
    output bcd_digit_t ones_o
);

    always_comb begin
        tens_o = tens_i;
        ones_o = ones_i;
        if (en_i) begin
            if (tens_i == 4'd9 && ones_i == 4'd9) begin
                tens_o = tens_i;
                ones_o = ones_i;
            end else if (ones_i == 4'd9) begin
                ones_o = '0;
                tens_o = tens_i + 4'd1;
            end else begin
                ones_o = ones_i + 4'd1;
            end
        end
    end

endmodule

// File: rtl/hit_frame_manager.sv
// Turns per-pixel collision flags into at most one scoring hit per frame and
// sequences the game through idle, play, post-hit cooldown and win.
module hit_frame_manager
    import game_pkg::*;
#(
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned TARGET_SCORE    = 20
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       collision,
    input  logic       startOfFrame,
    input  logic       startGame,
    output logic       hitPulse,
    output logic [3:0] scoreTens,
    output logic [3:0] scoreOnes,
    output logic [1:0] gameState,
    output logic       win
);

    localparam logic [7:0] TARGET_BCD = bin_to_bcd(TARGET_SCORE);
    localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);

    game_state_t state_q;
    logic        seen_q;
    logic [7:0]  cnt_q;
    bcd_digit_t  tens_q, ones_q;
    bcd_digit_t  tens_d, ones_d;
    logic        hit_q;
    logic        hit_now;

    // A collision coinciding with startOfFrame still belongs to the closing frame.
    assign hit_now = (state_q == ST_PLAY) && startOfFrame && (seen_q || collision);

    bcd_incrementer u_inc (
        .en_i   (hit_now),
        .tens_i (tens_q),
        .ones_i (ones_q),
        .tens_o (tens_d),
        .ones_o (ones_d)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            hit_q <= hit_now;
            case (state_q)
                ST_IDLE, ST_WIN: begin
                    seen_q <= 1'b0;
                    if (startGame) begin
                        state_q <= ST_PLAY;
                        tens_q  <= '0;
                        ones_q  <= '0;
                    end
                end
                ST_PLAY: begin
                    if (startOfFrame) begin
                        seen_q <= 1'b0;
                        if (hit_now) begin
                            tens_q <= tens_d;
                            ones_q <= ones_d;
                            if ({tens_d, ones_d} == TARGET_BCD) begin
                                state_q <= ST_WIN;
                            end else begin
                                state_q <= ST_COOLDOWN;
                                cnt_q   <= COOLDOWN_LOAD;
                            end
                        end
                    end else if (collision) begin
                        seen_q <= 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    seen_q <= 1'b0;
                    if (startOfFrame) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                        if (cnt_q <= 8'd1) begin
                            state_q <= ST_PLAY;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign hitPulse  = hit_q;
    assign scoreTens = tens_q;
    assign scoreOnes = ones_q;
    assign gameState = state_q;
    assign win       = (state_q == ST_WIN);

endmodule

// File: tb/tb_hit_frame_manager.sv
// Scoreboard bench for hit_frame_manager (COOLDOWN_FRAMES=3, TARGET_SCORE=12).
module tb_hit_frame_manager;

    localparam int FL = 16;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       collision = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       startGame = 1'b0;
    logic       hitPulse;
    logic [3:0] scoreTens, scoreOnes;
    logic [1:0] gameState;
    logic       win;

    typedef struct {
        int t;
        int o;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hit_frame_manager #(
        .COOLDOWN_FRAMES (3),
        .TARGET_SCORE    (12)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .collision    (collision),
        .startOfFrame (startOfFrame),
        .startGame    (startGame),
        .hitPulse     (hitPulse),
        .scoreTens    (scoreTens),
        .scoreOnes    (scoreOnes),
        .gameState    (gameState),
        .win          (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_status(input string name, input int t, input int o, input int st);
        check({name, "_tens"}, int'(scoreTens), t);
        check({name, "_ones"}, int'(scoreOnes), o);
        check({name, "_state"}, int'(gameState), st);
        check({name, "_win"}, int'(win), (st == 3) ? 1 : 0);
    endtask

    task automatic step(input logic col, input logic sof, input logic sg);
        collision    = col;
        startOfFrame = sof;
        startGame    = sg;
        @(posedge clk);
        #1;
    endtask

    // ncol collision cycles starting at cycle 2, then one startOfFrame cycle.
    task automatic frame(input int ncol, input logic col_sof, input logic sg_sof);
        for (int c = 0; c < FL - 1; c++) begin
            step((c >= 2 && c < 2 + ncol) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        step(col_sof, 1'b1, sg_sof);
        collision    = 1'b0;
        startOfFrame = 1'b0;
        startGame    = 1'b0;
    endtask

    // A hit frame reaching score s, preceded by three colliding cooldown frames.
    task automatic hit_after_cooldown(input int s, input int after_state);
        exp_t e;
        for (int f = 0; f < 3; f++) frame(FL - 4, 1'b1, 1'b0);
        check("cooldown_done", int'(gameState), 1);
        e.t = s / 10; e.o = s % 10; e.st = after_state;
        exp_q.push_back(e);
        frame(5, 1'b0, 1'b0);
    endtask

    // Monitor: every presented hitPulse must match the next queued expectation.
    always @(negedge clk) begin
        if (resetN && hitPulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_tens", int'(scoreTens), e.t);
                check("pulse_ones", int'(scoreOnes), e.o);
                check("pulse_state", int'(gameState), e.st);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_pulse", int'(hitPulse), 0);
        check_status("rst", 0, 0, 0);
        resetN = 1'b1;
        step(0, 0, 0);

        // IDLE ignores collisions entirely
        frame(FL - 3, 1'b1, 1'b0);
        check_status("idle", 0, 0, 0);

        step(0, 0, 1);
        check_status("start", 0, 0, 1);

        // Single hit: 10 collision pixels in one frame
        e.t = 0; e.o = 1; e.st = 2;
        exp_q.push_back(e);
        frame(10, 1'b0, 1'b0);
        check("hit1_pulse_now", int'(hitPulse), 1);
        check_status("hit1", 0, 1, 2);
        step(0, 0, 0);
        check("hit1_pulse_width", int'(hitPulse), 0);

        // Cooldown: three colliding frames blocked, back to PLAY, then hit 02
        frame(FL - 4, 1'b1, 1'b0);
        check("cd1_state", int'(gameState), 2);
        frame(FL - 4, 1'b1, 1'b0);
        check("cd2_state", int'(gameState), 2);
        frame(FL - 4, 1'b1, 1'b0);
        check_status("cd3", 0, 1, 1);
        e.t = 0; e.o = 2; e.st = 2;
        exp_q.push_back(e);
        frame(3, 1'b0, 1'b0);
        check_status("hit2", 0, 2, 2);

        // Quiet cooldown, then a quiet PLAY frame stays in PLAY
        for (int f = 0; f < 3; f++) frame(0, 1'b0, 1'b0);
        frame(0, 1'b0, 1'b0);
        check_status("quiet_play", 0, 2, 1);

        // Collision only in the startOfFrame cycle counts
        e.t = 0; e.o = 3; e.st = 2;
        exp_q.push_back(e);
        frame(0, 1'b1, 1'b0);
        check_status("sof_col_hit", 0, 3, 2);

        // Hits 4..12 including the 09 -> 10 carry and the win
        for (int s = 4; s <= 12; s++) begin
            hit_after_cooldown(s, (s == 12) ? 3 : 2);
            if (s == 9)  check_status("score09", 0, 9, 2);
            if (s == 10) check_status("score10", 1, 0, 2);
        end
        check_status("win", 1, 2, 3);

        // WIN freezes score and ignores collisions and cooldown
        for (int f = 0; f < 4; f++) frame(FL - 4, 1'b1, 1'b0);
        check_status("win_frozen", 1, 2, 3);

        // startGame together with startOfFrame in WIN: PLAY, score 00, no hit
        frame(10, 1'b1, 1'b1);
        check("restart_pulse", int'(hitPulse), 0);
        check_status("restart", 0, 0, 1);

        // Climb to 05, then reset mid-cooldown
        e.t = 0; e.o = 1; e.st = 2;
        exp_q.push_back(e);
        frame(4, 1'b0, 1'b0);
        for (int s = 2; s <= 5; s++) hit_after_cooldown(s, 2);
        check_status("pre_reset", 0, 5, 2);
        for (int c = 0; c < 5; c++) step(1, 0, 0);
        #2;
        resetN = 1'b0;
        #1;
        check("async_rst_pulse", int'(hitPulse), 0);
        check_status("async_rst", 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        check_status("post_rst", 0, 0, 0);
        frame(FL - 3, 1'b1, 1'b0);
        check_status("post_rst_frame", 0, 0, 0);

        repeat (3) step(0, 0, 0);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
